// File: rtl/button_debouncer.sv
// button_debouncer: per-button 2-flop synchronizer, debounce FSM and press/release pulses.
// Define BUTTON_REPEAT_EN to add hold-to-repeat pulses; otherwise repeat_pulse is tied to 0.
module button_debouncer #(
  parameter int NUM_BUTTONS         = 2,
  parameter int DEBOUNCE_CYCLES     = 270000,
  parameter int REPEAT_DELAY_CYCLES = 13500000,
  parameter int REPEAT_RATE_CYCLES  = 2700000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] btn_n,
  output logic [NUM_BUTTONS-1:0] pressed,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse,
  output logic [NUM_BUTTONS-1:0] repeat_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BUTTON_REPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                            REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE_CYCLES - 1);
`endif

  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  // Elaboration-time sanity checks on the configuration.
  if (NUM_BUTTONS < 1) begin : g_bad_num
    $error("button_debouncer: NUM_BUTTONS must be >= 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("button_debouncer: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY_CYCLES < 1 || REPEAT_RATE_CYCLES < 1) begin : g_bad_repeat
    $error("button_debouncer: repeat delay and rate must be >= 1");
  end

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    logic             s1;
    logic             s2;
    logic             low;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pressed_q;
    logic             press_q;
    logic             release_q;
`ifdef BUTTON_REPEAT_EN
    logic [HOLD_W-1:0] hold;
    logic              repeating;
    logic              repeat_q;
`endif

    assign low = ~s2;

    // Synchronizer resets to the released (high) pin level.
    always_ff @(posedge clk) begin
      if (rst) begin
        s1 <= 1'b1;
        s2 <= 1'b1;
      end else begin
        s1 <= btn_n[i];
        s2 <= s1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state     <= RELEASED;
        cnt       <= '0;
        pressed_q <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
`ifdef BUTTON_REPEAT_EN
        hold      <= '0;
        repeating <= 1'b0;
        repeat_q  <= 1'b0;
`endif
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
`ifdef BUTTON_REPEAT_EN
        repeat_q  <= 1'b0;
`endif
        case (state)
          RELEASED: begin
            if (low) begin
              state <= PRESS_WAIT;
              cnt   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!low) begin
              state <= RELEASED;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state     <= PRESSED;
              pressed_q <= 1'b1;
              press_q   <= 1'b1;
`ifdef BUTTON_REPEAT_EN
              hold      <= '0;
              repeating <= 1'b0;
`endif
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          PRESSED: begin
            if (!low) begin
              state <= RELEASE_WAIT;
              cnt   <= '0;
            end
`ifdef BUTTON_REPEAT_EN
            // The first repeat waits the long delay, later ones the shorter rate.
            else if (hold == (repeating ? RATE_LAST : DELAY_LAST)) begin
              repeat_q  <= 1'b1;
              repeating <= 1'b1;
              hold      <= '0;
            end else begin
              hold <= hold + HOLD_W'(1);
            end
`endif
          end
          RELEASE_WAIT: begin
            if (low) begin
              state <= PRESSED;
            end else if (cnt == CNT_LAST) begin
              state     <= RELEASED;
              pressed_q <= 1'b0;
              release_q <= 1'b1;
`ifdef BUTTON_REPEAT_EN
              hold      <= '0;
              repeating <= 1'b0;
`endif
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: state <= RELEASED;
        endcase
      end
    end

    assign pressed[i]       = pressed_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
`ifdef BUTTON_REPEAT_EN
    assign repeat_pulse[i]  = repeat_q;
`endif
  end

`ifndef BUTTON_REPEAT_EN
  assign repeat_pulse = '0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: expected output words are queued per cycle
// when stimulus is applied and popped/compared one cycle at a time after each rising edge.
module tb_button_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn_n;
  logic [1:0] pressed;
  logic [1:0] press_pulse;
  logic [1:0] release_pulse;
  logic [1:0] repeat_pulse;

  button_debouncer #(
    .NUM_BUTTONS         (2),
    .DEBOUNCE_CYCLES     (4),
    .REPEAT_DELAY_CYCLES (10),
    .REPEAT_RATE_CYCLES  (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_n         (btn_n),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse)
  );

  always #5 clk = ~clk;

  // Output word layout: {repeat_pulse, release_pulse, press_pulse, pressed}.
`ifdef BUTTON_REPEAT_EN
  localparam logic [7:0] HELD0_REP = 8'h41;
`else
  localparam logic [7:0] HELD0_REP = 8'h01;
`endif

  typedef struct {
    int         cyc;
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic applyStimulus(input logic rst_v, input logic [1:0] btn_v);
    rst   = rst_v;
    btn_n = btn_v;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s cycle=%0d got=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic expectRange(input string tag, input int from, input int to,
                             input logic [7:0] val);
    exp_t e;
    for (int k = from; k <= to; k++) begin
      e.cyc = k;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checkOutput(e.tag, {repeat_pulse, release_pulse, press_pulse, pressed}, e.val);
    end
  endtask

  task automatic runUntil(input int last);
    while (cyc < last) step();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Both buttons held through reset, re-detected after deassert.
    applyStimulus(1'b1, 2'b00);
    expectRange("reset", 1, 3, 8'h00);
    runUntil(3);
    applyStimulus(1'b0, 2'b00);
    expectRange("rst_wait", 4, 9, 8'h00);
    expectRange("rst_press", 10, 10, 8'h0F);
    expectRange("rst_held", 11, 12, 8'h03);
    runUntil(12);
    applyStimulus(1'b0, 2'b11);
    expectRange("rst_relwait", 13, 18, 8'h03);
    expectRange("rst_release", 19, 19, 8'h30);
    expectRange("idle1", 20, 22, 8'h00);
    runUntil(22);

    // Clean press on channel 0 with a long hold (repeats when enabled).
    applyStimulus(1'b0, 2'b10);
    expectRange("clean_wait", 23, 28, 8'h00);
    expectRange("clean_press", 29, 29, 8'h05);
    expectRange("clean_held", 30, 38, 8'h01);
    expectRange("repeat_first", 39, 39, HELD0_REP);
    expectRange("clean_held", 40, 41, 8'h01);
    expectRange("repeat_second", 42, 42, HELD0_REP);
    expectRange("clean_held", 43, 44, 8'h01);
    runUntil(44);
    applyStimulus(1'b0, 2'b11);
    expectRange("repeat_third", 45, 45, HELD0_REP);
    expectRange("clean_relwait", 46, 50, 8'h01);
    expectRange("clean_release", 51, 51, 8'h10);
    expectRange("idle2", 52, 54, 8'h00);
    runUntil(54);

    // Press bounce shorter than the debounce window is rejected.
    expectRange("press_bounce", 55, 70, 8'h00);
    applyStimulus(1'b0, 2'b10);
    runUntil(57);
    applyStimulus(1'b0, 2'b11);
    runUntil(59);
    applyStimulus(1'b0, 2'b10);
    runUntil(61);
    applyStimulus(1'b0, 2'b11);
    runUntil(70);

    // Release bounce while held keeps pressed high.
    expectRange("rb_wait", 71, 76, 8'h00);
    expectRange("rb_press", 77, 77, 8'h05);
    expectRange("rb_held", 78, 91, 8'h01);
    expectRange("rb_release", 92, 92, 8'h10);
    expectRange("idle3", 93, 95, 8'h00);
    applyStimulus(1'b0, 2'b10);
    runUntil(80);
    applyStimulus(1'b0, 2'b11);
    runUntil(83);
    applyStimulus(1'b0, 2'b10);
    runUntil(85);
    applyStimulus(1'b0, 2'b11);
    runUntil(95);

    // Simultaneous press and release on both channels.
    applyStimulus(1'b0, 2'b00);
    expectRange("sim_wait", 96, 101, 8'h00);
    expectRange("sim_press", 102, 102, 8'h0F);
    expectRange("sim_held", 103, 105, 8'h03);
    runUntil(105);
    applyStimulus(1'b0, 2'b11);
    expectRange("sim_relwait", 106, 111, 8'h03);
    expectRange("sim_release", 112, 112, 8'h30);
    expectRange("idle4", 113, 115, 8'h00);
    runUntil(115);

    // Presses staggered by one cycle give staggered pulses.
    applyStimulus(1'b0, 2'b10);
    runUntil(116);
    applyStimulus(1'b0, 2'b00);
    expectRange("stag_wait", 117, 121, 8'h00);
    expectRange("stag_press0", 122, 122, 8'h05);
    expectRange("stag_press1", 123, 123, 8'h0B);
    expectRange("stag_held", 124, 125, 8'h03);
    runUntil(125);
    applyStimulus(1'b0, 2'b11);
    expectRange("stag_relwait", 126, 131, 8'h03);
    expectRange("stag_release", 132, 132, 8'h30);
    expectRange("idle5", 133, 135, 8'h00);
    runUntil(135);

    // Reset in the middle of PRESS_WAIT restarts the full latency.
    applyStimulus(1'b0, 2'b10);
    expectRange("midrst_wait", 136, 147, 8'h00);
    expectRange("midrst_press", 148, 148, 8'h05);
    expectRange("midrst_held", 149, 150, 8'h01);
    runUntil(139);
    applyStimulus(1'b1, 2'b10);
    runUntil(141);
    applyStimulus(1'b0, 2'b10);
    runUntil(150);
    applyStimulus(1'b0, 2'b11);
    expectRange("midrst_relwait", 151, 156, 8'h01);
    expectRange("midrst_release", 157, 157, 8'h10);
    expectRange("idle6", 158, 160, 8'h00);
    runUntil(160);

    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL scoreboard_drain got=%0d pending expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
